// File: rtl/norm_pkg.sv
// norm_pkg
//   Shared types and helpers for the streaming column-norm block.
//   - state_t   : controller states (IDLE, ACCUM, DRAIN)
//   - MODE_*    : encodings of the mode input
//   - sat_pos   : clamp a non-negative value to the largest positive n-bit
//                 two's complement number, flagging when clamping happened
//   - sat_add   : add two non-negative n-bit values with the same clamp
//   The helpers work on a wide SAT_W container and take the data width n as
//   an argument, so every module can share them whatever its own N is
//   (N up to 64, because squares need 2N bits).
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic MODE_L2SQ = 1'b0;
    localparam logic MODE_L1   = 1'b1;

    localparam int SAT_W = 128;

    // Largest positive value of an n-bit two's complement number.
    function automatic logic [SAT_W-1:0] pos_limit(input int unsigned n);
        return (SAT_W'(1) << (n - 1)) - SAT_W'(1);
    endfunction

    // v is known non-negative. It is clamped to pos_limit(n).
    function automatic logic [SAT_W-1:0] sat_pos(input  logic [SAT_W-1:0] v,
                                                 input  int unsigned      n,
                                                 output logic             ovf);
        logic [SAT_W-1:0] lim;
        lim = pos_limit(n);
        ovf = (v > lim);
        return ovf ? lim : v;
    endfunction

    // Both operands are already within [0, pos_limit(n)], so their sum
    // cannot wrap inside the wide container before it is clamped.
    function automatic logic [SAT_W-1:0] sat_add(input  logic [SAT_W-1:0] a,
                                                 input  logic [SAT_W-1:0] b,
                                                 input  int unsigned      n,
                                                 output logic             ovf);
        return sat_pos(a + b, n, ovf);
    endfunction

endpackage

// File: rtl/norm_lane.sv
// norm_lane
//   Combinational per-lane term generator. It turns one signed Q-format
//   sample into the non-negative term that the column accumulator sums.
//   Ports:
//     mode  in   1   MODE_L2SQ: (x*x) >>> Q, MODE_L1: |x|
//     x     in   N   signed sample
//     term  out  N   non-negative term, clamped to 2^(N-1)-1
//     ovf   out  1   the term had to be clamped
module norm_lane
    import norm_pkg::*;
#(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic         mode,
    input  logic [N-1:0] x,
    output logic [N-1:0] term,
    output logic         ovf
);

    logic signed [2*N-1:0] x_ext;
    logic signed [2*N-1:0] square;
    logic signed [2*N-1:0] scaled;
    logic signed [2*N-1:0] magnitude;
    logic        [2*N-1:0] pick;

    // Both candidates are formed at 2N bits. The square of an N-bit value
    // always fits there, and the magnitude of the most negative sample
    // (2^(N-1)) is representable before it is clamped, which is how that
    // single corner case ends up flagged through the common saturation path.
    always_comb begin
        logic lane_sat;
        x_ext     = {{N{x[N-1]}}, x};
        square    = x_ext * x_ext;
        scaled    = square >>> Q;
        magnitude = x_ext[2*N-1] ? -x_ext : x_ext;
        pick      = (mode == MODE_L1) ? magnitude : scaled;
        term      = N'(sat_pos(SAT_W'(pick), N, lane_sat));
        ovf       = lane_sat;
    end

endmodule

// File: rtl/column_norm_stream.sv
// column_norm_stream
//   Streaming per-column norm engine. An I x J signed Q-format matrix
//   arrives row by row in L-lane beats. Each column accumulates either the
//   sum of squares or the sum of magnitudes. The J results then leave in
//   L-lane beats over a valid/ready stream.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     start, mode         begin a matrix (taken in IDLE only), statistic select
//     busy                matrix in progress (ACCUM or DRAIN)
//     in_valid/in_ready   input beat handshake, in_data is L lanes of N bits
//     out_valid/out_ready result beat handshake, out_data is L lanes of N bits
//     out_last            final result beat of the matrix
//     done                one-cycle pulse after the final result beat is taken
//     overflow            sticky saturation flag, cleared by the next start
module column_norm_stream
    import norm_pkg::*;
#(
    parameter int I = 20,
    parameter int J = 240,
    parameter int L = 8,
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [L-1:0][N-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [L-1:0][N-1:0] out_data,
    output logic                out_last,
    output logic                done,
    output logic                overflow
);

    localparam int SEGS  = J / L;
    localparam int SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam int ROW_W = (I > 1) ? $clog2(I) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEGS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(I - 1);

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 in_done_q, in_done_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;

    logic                 pipe_valid_q, pipe_valid_d;
    logic [SEG_W-1:0]     pipe_seg_q, pipe_seg_d;
    logic                 pipe_first_q, pipe_first_d;
    logic [L-1:0][N-1:0]  pipe_term_q, pipe_term_d;
    logic                 pipe_ovf_q, pipe_ovf_d;

    logic [N-1:0]         acc_q [J];
    logic [N-1:0]         acc_d [J];

    logic [L-1:0][N-1:0]  lane_term;
    logic [L-1:0]         lane_ovf;
    logic [L-1:0][N-1:0]  acc_rd;
    logic [L-1:0][N-1:0]  acc_new;
    logic [L-1:0]         add_ovf;
    logic [L-1:0][N-1:0]  drain_word;
    logic                 in_fire;
    logic                 out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    for (genvar l = 0; l < L; l++) begin : g_lane
        norm_lane #(
            .N(N),
            .Q(Q)
        ) u_lane (
            .mode(mode_q),
            .x   (in_data[l]),
            .term(lane_term[l]),
            .ovf (lane_ovf[l])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. ACCUM hands over to DRAIN one cycle after the last
    // input beat, which is the cycle in which that beat's terms reach the
    // accumulator bank.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)                state_d = ACCUM;
            ACCUM:   if (in_done_q)            state_d = DRAIN;
            DRAIN:   if (out_fire && out_last) state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Outputs decoded from state. out_data is forced to zero outside DRAIN
    // so the result bus is quiet whenever no beat is being offered.
    always_comb begin
        busy      = (state_q != IDLE);
        in_ready  = (state_q == ACCUM) && !in_done_q;
        out_valid = (state_q == DRAIN);
        out_last  = out_valid && (seg_q == SEG_LAST);
        out_data  = '0;
        if (out_valid) begin
            out_data = drain_word;
        end
        done      = done_q;
        overflow  = overflow_q;
    end

    // Segment/row bookkeeping. seg_q is shared by both phases. It walks the
    // input segments in ACCUM and wraps to zero on the last beat, so DRAIN
    // starts from segment zero without an extra clear.
    always_comb begin
        mode_d     = mode_q;
        seg_d      = seg_q;
        row_d      = row_q;
        in_done_d  = in_done_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    seg_d      = '0;
                    row_d      = '0;
                    in_done_d  = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    if (seg_q == SEG_LAST) begin
                        seg_d = '0;
                        if (row_q == ROW_LAST) begin
                            in_done_d = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        seg_d = seg_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    seg_d = (seg_q == SEG_LAST) ? '0 : seg_q + 1'b1;
                    if (out_last) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (pipe_valid_q && (pipe_ovf_q || (|add_ovf))) begin
            overflow_d = 1'b1;
        end
    end

    // Term pipeline stage. The terms and their column address are captured
    // on an accepted beat and held otherwise, so only pipe_valid toggles on
    // idle cycles.
    always_comb begin
        pipe_valid_d = in_fire;
        pipe_seg_d   = pipe_seg_q;
        pipe_first_d = pipe_first_q;
        pipe_term_d  = pipe_term_q;
        pipe_ovf_d   = pipe_ovf_q;
        if (in_fire) begin
            pipe_seg_d   = seg_q;
            pipe_first_d = (row_q == '0);
            pipe_term_d  = lane_term;
            pipe_ovf_d   = |lane_ovf;
        end
    end

    // Control and pipeline registers that need a defined reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_L2SQ;
            seg_q        <= '0;
            row_q        <= '0;
            in_done_q    <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            pipe_valid_q <= 1'b0;
            pipe_seg_q   <= '0;
            pipe_first_q <= 1'b0;
            pipe_term_q  <= '0;
            pipe_ovf_q   <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            seg_q        <= seg_d;
            row_q        <= row_d;
            in_done_q    <= in_done_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_seg_q   <= pipe_seg_d;
            pipe_first_q <= pipe_first_d;
            pipe_term_q  <= pipe_term_d;
            pipe_ovf_q   <= pipe_ovf_d;
        end
    end

    // Read the L accumulators addressed by the pipelined segment.
    always_comb begin
        acc_rd = '0;
        for (int j = 0; j < J; j++) begin
            if (pipe_seg_q == SEG_W'(j / L)) begin
                acc_rd[j % L] = acc_q[j];
            end
        end
    end

    // Row 0 overwrites the accumulator, which removes the need for a clear
    // pass between matrices. Later rows add with saturation.
    always_comb begin
        logic lane_sat;
        add_ovf = '0;
        acc_new = '0;
        for (int l = 0; l < L; l++) begin
            acc_new[l] = N'(sat_add(SAT_W'(acc_rd[l]), SAT_W'(pipe_term_q[l]), N, lane_sat));
            add_ovf[l] = lane_sat && !pipe_first_q;
            if (pipe_first_q) begin
                acc_new[l] = pipe_term_q[l];
            end
        end
    end

    // Write back only the columns of the committed segment.
    always_comb begin
        for (int j = 0; j < J; j++) begin
            acc_d[j] = acc_q[j];
            if (pipe_valid_q && (pipe_seg_q == SEG_W'(j / L))) begin
                acc_d[j] = acc_new[j % L];
            end
        end
    end

    // The accumulator bank has no reset. Its contents are always rewritten
    // by row 0 of the next matrix before they are read.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    // Output mux for the segment currently being drained.
    always_comb begin
        drain_word = '0;
        for (int j = 0; j < J; j++) begin
            if (seg_q == SEG_W'(j / L)) begin
                drain_word[j % L] = acc_q[j];
            end
        end
    end

endmodule

// File: tb/tb_column_norm_stream.sv
module tb_column_norm_stream;

    localparam int I    = 2;
    localparam int J    = 4;
    localparam int L    = 2;
    localparam int N    = 16;
    localparam int SEGS = J / L;
    localparam int NV   = 6;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic mode;
    logic in_valid;
    logic out_ready;
    logic [L-1:0][N-1:0] in_data;

    logic busy0, in_ready0, out_valid0, out_last0, done0, overflow0;
    logic [L-1:0][N-1:0] out_data0;
    logic busy8, in_ready8, out_valid8, out_last8, done8, overflow8;
    logic [L-1:0][N-1:0] out_data8;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic                  mode;
        logic                  gaps;
        logic                  stall;
        logic [I*J-1:0][15:0]  mat;
        logic [J-1:0][15:0]    exp0;
        logic                  ovf0;
        logic [J-1:0][15:0]    exp8;
        logic                  ovf8;
    } vec_t;

    vec_t vecs [NV];

    logic [J-1:0][15:0] got0;
    logic [J-1:0][15:0] got8;
    logic [SEGS-1:0]    got_last;

    always #5 clk = ~clk;

    column_norm_stream #(.I(I), .J(J), .L(L), .Q(0), .N(N)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy0),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_last(out_last0), .done(done0), .overflow(overflow0)
    );

    column_norm_stream #(.I(I), .J(J), .L(L), .Q(8), .N(N)) dut8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy8),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .out_last(out_last8), .done(done8), .overflow(overflow8)
    );

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0][15:0] row4(input int a, input int b, input int c, input int d);
        logic [3:0][15:0] r;
        r[0] = 16'(a);
        r[1] = 16'(b);
        r[2] = 16'(c);
        r[3] = 16'(d);
        return r;
    endfunction

    // Column statistics straight from the arithmetic definition: per element
    // term, clamp at 32767, then a clamped running column sum.
    function automatic void refModel(input logic [I*J-1:0][15:0] m, input logic md, input int q,
                                     output logic [J-1:0][15:0] res, output logic ovf);
        longint lim;
        longint acc;
        longint x;
        longint t;
        lim = 32767;
        ovf = 1'b0;
        res = '0;
        for (int c = 0; c < J; c++) begin
            acc = 0;
            for (int r = 0; r < I; r++) begin
                x = longint'($signed(m[r*J+c]));
                if (md) t = (x < 0) ? -x : x;
                else    t = (x * x) >>> q;
                if (t > lim) begin
                    t = lim;
                    ovf = 1'b1;
                end
                acc = acc + t;
                if (acc > lim) begin
                    acc = lim;
                    ovf = 1'b1;
                end
            end
            res[c] = 16'(acc);
        end
    endfunction

    task automatic checkReset();
        checkVal("rst_busy0", busy0, 0);
        checkVal("rst_in_ready0", in_ready0, 0);
        checkVal("rst_out_valid0", out_valid0, 0);
        checkVal("rst_out_last0", out_last0, 0);
        checkVal("rst_done0", done0, 0);
        checkVal("rst_overflow0", overflow0, 0);
        checkVal("rst_out_data0", out_data0, 0);
        checkVal("rst_busy8", busy8, 0);
        checkVal("rst_overflow8", overflow8, 0);
        checkVal("rst_out_data8", out_data8, 0);
    endtask

    task automatic doStart(input vec_t v);
        @(negedge clk);
        start = 1'b1;
        mode  = v.mode;
        @(negedge clk);
        start = 1'b0;
        mode  = ~v.mode;
        checkVal("busy_after_start", busy0, 1);
        checkVal("ovf_cleared0", overflow0, 0);
        checkVal("ovf_cleared8", overflow8, 0);
    endtask

    task automatic feedBeats(input vec_t v, input int n_beats);
        int r;
        int s;
        int g;
        int guard;
        for (int b = 0; b < n_beats; b++) begin
            r = b / SEGS;
            s = b % SEGS;
            if (v.gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = {$urandom, $urandom};
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            for (int l = 0; l < L; l++) in_data[l] = v.mat[r*J + s*L + l];
            guard = 0;
            while (!in_ready0 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20) checkVal("in_ready_timeout", 0, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
    endtask

    task automatic drainResults(input vec_t v, input bit pulse_start);
        int b;
        int guard;
        bit have_prev;
        bit pulsed;
        logic [L-1:0][N-1:0] prev_data;
        logic prev_last;
        b = 0;
        guard = 0;
        have_prev = 0;
        pulsed = 0;
        while (b < SEGS && guard < 200) begin
            @(negedge clk);
            guard++;
            start = 1'b0;
            if (pulse_start && out_valid0 && !pulsed) begin
                start  = 1'b1;
                mode   = ~v.mode;
                pulsed = 1;
            end
            out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (have_prev) begin
                checkVal("stall_data", out_data0, prev_data);
                checkVal("stall_last", out_last0, prev_last);
                have_prev = 0;
            end
            if (out_valid0) begin
                if (out_ready) begin
                    for (int l = 0; l < L; l++) begin
                        got0[b*L+l] = out_data0[l];
                        got8[b*L+l] = out_data8[l];
                    end
                    got_last[b] = out_last0;
                    checkVal("dut8_valid", out_valid8, 1);
                    b++;
                end else begin
                    have_prev = 1;
                    prev_data = out_data0;
                    prev_last = out_last0;
                end
            end
        end
        if (b < SEGS) checkVal("drain_timeout", b, SEGS);
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        checkVal("done_pulse0", done0, 1);
        checkVal("done_pulse8", done8, 1);
        checkVal("busy_after_done", busy0, 0);
        checkVal("valid_after_done", out_valid0, 0);
        @(negedge clk);
        checkVal("done_clear", done0, 0);
    endtask

    task automatic applyStimulus(input vec_t v, input bit pulse_start);
        doStart(v);
        feedBeats(v, I * SEGS);
        checkVal("in_ready_after_last", in_ready0, 0);
        checkVal("busy_commit", busy0, 1);
        drainResults(v, pulse_start);
    endtask

    task automatic checkOutput(input vec_t v, input int tag);
        for (int c = 0; c < J; c++) begin
            checkVal($sformatf("v%0d_q0_col%0d", tag, c), got0[c], v.exp0[c]);
            checkVal($sformatf("v%0d_q8_col%0d", tag, c), got8[c], v.exp8[c]);
        end
        for (int b = 0; b < SEGS; b++) begin
            checkVal($sformatf("v%0d_last%0d", tag, b), got_last[b], (b == SEGS - 1) ? 1 : 0);
        end
        checkVal($sformatf("v%0d_overflow0", tag), overflow0, v.ovf0);
        checkVal($sformatf("v%0d_overflow8", tag), overflow8, v.ovf8);
    endtask

    initial begin
        vec_t rv;
        logic [J-1:0][15:0] e;
        logic eo;
        int val;

        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        vecs[0] = '{mode: 1'b0, gaps: 1'b0, stall: 1'b0,
                    mat: {row4(5, 6, 7, 8), row4(1, 2, 3, 4)},
                    exp0: row4(26, 40, 58, 80), ovf0: 1'b0,
                    exp8: row4(0, 0, 0, 0), ovf8: 1'b0};
        vecs[1] = '{mode: 1'b1, gaps: 1'b0, stall: 1'b0,
                    mat: {row4(5, -6, 7, -8), row4(-1, 2, -3, 4)},
                    exp0: row4(6, 8, 10, 12), ovf0: 1'b0,
                    exp8: row4(6, 8, 10, 12), ovf8: 1'b0};
        vecs[2] = '{mode: 1'b1, gaps: 1'b0, stall: 1'b0,
                    mat: {row4(0, 0, 0, 0), row4(-32768, 1, 2, 3)},
                    exp0: row4(32767, 1, 2, 3), ovf0: 1'b1,
                    exp8: row4(32767, 1, 2, 3), ovf8: 1'b1};
        vecs[3] = '{mode: 1'b0, gaps: 1'b0, stall: 1'b0,
                    mat: {row4(1, 1, 1, 1), row4(200, 1, 2, 3)},
                    exp0: row4(32767, 2, 5, 10), ovf0: 1'b1,
                    exp8: row4(156, 0, 0, 0), ovf8: 1'b0};
        vecs[4] = '{mode: 1'b0, gaps: 1'b1, stall: 1'b1,
                    mat: {row4(5, 6, 7, 8), row4(1, 2, 3, 4)},
                    exp0: row4(26, 40, 58, 80), ovf0: 1'b0,
                    exp8: row4(0, 0, 0, 0), ovf8: 1'b0};
        vecs[5] = '{mode: 1'b0, gaps: 1'b0, stall: 1'b0,
                    mat: {row4(384, 256, 0, 0), row4(384, 256, 0, 0)},
                    exp0: row4(32767, 32767, 0, 0), ovf0: 1'b1,
                    exp8: row4(1152, 512, 0, 0), ovf8: 1'b0};

        repeat (3) @(negedge clk);
        checkReset();
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            applyStimulus(vecs[k], 1'b0);
            checkOutput(vecs[k], k);
        end

        $display("[TB] reset during accumulation");
        doStart(vecs[3]);
        feedBeats(vecs[3], 3);
        checkVal("ovf_before_rst", overflow0, 1);
        rst = 1'b1;
        @(negedge clk);
        checkReset();
        rst = 1'b0;
        applyStimulus(vecs[0], 1'b1);
        checkOutput(vecs[0], 10);

        $display("[TB] randomized matrices");
        for (int k = 0; k < 10; k++) begin
            rv = '0;
            rv.mode  = 1'($urandom_range(0, 1));
            rv.gaps  = 1'b1;
            rv.stall = 1'b1;
            for (int idx = 0; idx < I*J; idx++) begin
                if ($urandom_range(0, 3) == 0) val = int'($urandom);
                else val = int'($urandom_range(0, 600)) - 300;
                rv.mat[idx] = 16'(val);
            end
            refModel(rv.mat, rv.mode, 0, e, eo);
            rv.exp0 = e;
            rv.ovf0 = eo;
            refModel(rv.mat, rv.mode, 8, e, eo);
            rv.exp8 = e;
            rv.ovf8 = eo;
            applyStimulus(rv, k[0]);
            checkOutput(rv, 20 + k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
